// File: rtl/rxuart_ovs.sv
// rxuart_ovs - oversampling UART receiver for the serial command path.
//
// Each bit is decided by a 3-sample majority vote around mid-bit. Start
// glitches are rejected silently, and a line held low is reported once as a
// break. All per-frame status is delivered as one-cycle pulses in the single
// DONE cycle.
//
// Optional feature macro: RXUART_PARITY_EN
//   defined   - one parity bit follows the data bits, PARITY_ODD selects the
//               sense and o_parity_err is live.
//   undefined - frame is start + DATA_BITS + STOP_BITS, o_parity_err is 0.
module rxuart_ovs #(
    parameter int CLOCK_DIVIDE = 78,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break_det,
    output logic                 o_is_receiving
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality checks
    // ------------------------------------------------------------------
    generate
        if (CLOCK_DIVIDE < 1) begin : g_bad_clock_divide
            $error("rxuart_ovs: CLOCK_DIVIDE must be >= 1");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
            $error("rxuart_ovs: OVERSAMPLE must be even and >= 8");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
            $error("rxuart_ovs: DATA_BITS must be 5..9");
        end
        if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
            $error("rxuart_ovs: STOP_BITS must be 1 or 2");
        end
        if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
            $error("rxuart_ovs: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int CNT_W = 4;

    localparam logic [DIV_W-1:0] DIV_TOP   = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_LO    = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_MID   = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0] SMP_HI    = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef RXUART_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_DONE    = 3'd5,
        S_BRKWAIT = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef RXUART_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    // XOR of all data bits and the received parity bit
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic [DIV_W-1:0]     r_div;
    logic [SMP_W-1:0]     r_samp;
    logic                 r_v0;
    logic                 r_v1;
    state_t               r_state;
    logic [CNT_W-1:0]     r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
`ifdef RXUART_PARITY_EN
    logic                 r_par;
`endif

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_break_det;
    logic                 r_is_receiving;

    state_t               w_next_state;
    logic                 w_start_det;
    logic                 w_tick;
    logic                 w_decide;
    logic                 w_vote;
    logic                 w_stop_low;
    logic                 w_break_now;
    logic                 w_enter_done;
    logic                 w_perr;
    logic                 w_last_data;
    logic                 w_last_stop;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    assign w_start_det  = (r_state == S_IDLE) && !r_sync2;
    assign w_tick       = (r_div == DIV_W'(0));
    assign w_decide     = w_tick && (r_samp == SMP_HI);
    // r_sync2 is the third sample: the decision is taken at the last vote index
    assign w_vote       = majority3(r_v0, r_v1, r_sync2);
    assign w_last_data  = (r_bitcnt == LAST_DATA);
    assign w_last_stop  = (r_bitcnt == LAST_STOP);
    assign w_stop_low   = (r_state == S_STOP) && w_decide && !w_vote;
    assign w_enter_done = (r_state == S_STOP) && (w_next_state == S_DONE);

`ifdef RXUART_PARITY_EN
    assign w_break_now = w_stop_low && (r_bitcnt == CNT_W'(0)) &&
                         (r_shift == DATA_BITS'(0)) && !r_par;
    assign w_perr      = frame_parity(r_shift, r_par) ^ PAR_SENSE;
`else
    assign w_break_now = w_stop_low && (r_bitcnt == CNT_W'(0)) &&
                         (r_shift == DATA_BITS'(0));
    assign w_perr      = 1'b0;
`endif

    // Two-flop synchroniser on the asynchronous line, idling high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Tick divider and per-bit sample index, realigned on every start edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= DIV_W'(0);
            r_samp <= SMP_W'(0);
        end else if (w_start_det) begin
            r_div  <= DIV_TOP;
            r_samp <= SMP_W'(0);
        end else if (w_tick) begin
            r_div  <= DIV_TOP;
            r_samp <= (r_samp == SMP_LAST) ? SMP_W'(0) : (r_samp + SMP_W'(1));
        end else begin
            r_div  <= r_div - DIV_W'(1);
        end
    end

    // Capture the two samples that precede the mid-bit decision
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else begin
            if (w_tick && (r_samp == SMP_LO)) begin
                r_v0 <= r_sync2;
            end
            if (w_tick && (r_samp == SMP_MID)) begin
                r_v1 <= r_sync2;
            end
        end
    end

    // Frame state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; transitions only on bit decisions except IDLE/DONE/BRKWAIT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_decide) begin
                    // a start bit that votes high was a glitch
                    w_next_state = w_vote ? S_IDLE : S_DATA;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (w_decide && w_last_data) begin
`ifdef RXUART_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end else begin
                    w_next_state = S_DATA;
                end
            end
`ifdef RXUART_PARITY_EN
            S_PARITY: begin
                if (w_decide) begin
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_decide && (w_break_now || w_last_stop)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_STOP;
                end
            end
            S_DONE: begin
                // the break flag registered on DONE entry selects the exit
                if (r_break_det) begin
                    w_next_state = S_BRKWAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BRKWAIT: begin
                if (r_sync2) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_BRKWAIT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Frame datapath: bit counter, data shift register, parity bit, stop errors
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bitcnt <= CNT_W'(0);
            r_shift  <= DATA_BITS'(0);
            r_ferr   <= 1'b0;
`ifdef RXUART_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_START: begin
                    if (w_decide && !w_vote) begin
                        r_bitcnt <= CNT_W'(0);
                        r_ferr   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0
                        r_shift  <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= w_last_data ? CNT_W'(0) : (r_bitcnt + CNT_W'(1));
                    end
                end
`ifdef RXUART_PARITY_EN
                S_PARITY: begin
                    if (w_decide) begin
                        r_par <= w_vote;
                    end
                end
`endif
                S_STOP: begin
                    if (w_decide) begin
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs: strobes are set only on the edge that enters DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_data      <= DATA_BITS'(0);
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_parity_err   <= 1'b0;
            r_break_det    <= 1'b0;
            r_is_receiving <= 1'b0;
        end else begin
            r_rx_valid     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_parity_err   <= 1'b0;
            r_break_det    <= 1'b0;
            r_is_receiving <= (w_next_state != S_IDLE);
            if (w_enter_done) begin
                r_frame_err <= r_ferr | w_stop_low;
                if (w_break_now) begin
                    // a break keeps the previous word on o_rx_data
                    r_break_det <= 1'b1;
                end else begin
                    r_rx_data    <= r_shift;
                    r_rx_valid   <= 1'b1;
                    r_parity_err <= w_perr;
                end
            end
        end
    end

    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_frame_err    = r_frame_err;
    assign o_parity_err   = r_parity_err;
    assign o_break_det    = r_break_det;
    assign o_is_receiving = r_is_receiving;

endmodule

// File: tb/tb_rxuart_ovs.sv
// tb_rxuart_ovs - directed bench for rxuart_ovs with 4 clk per tick, 16 ticks per bit.
module tb_rxuart_ovs;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       break_det;
    logic       is_receiving;

    int checks = 0;
    int errors = 0;

    rxuart_ovs #(
        .CLOCK_DIVIDE (4),
        .OVERSAMPLE   (16),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_ODD   (0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx           (rx),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_frame_err    (frame_err),
        .o_parity_err   (parity_err),
        .o_break_det    (break_det),
        .o_is_receiving (is_receiving)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and records timing/data of rx_valid events
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_brk = 0;
    int         n_ferr_w_valid = 0;
    int         n_ferr_w_brk = 0;
    int         n_consec = 0;
    int         t_valid_last = 0;
    int         t_valid_prev = 0;
    logic [7:0] d_last = 8'h00;
    logic [7:0] d_prev = 8'h00;
    logic       any_prev = 1'b0;
    logic       valid_prev = 1'b0;
    logic       isr_at_valid = 1'b0;
    logic       isr_after_valid = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            n_valid      <= n_valid + 1;
            t_valid_prev <= t_valid_last;
            t_valid_last <= cyc;
            d_prev       <= d_last;
            d_last       <= rx_data;
            isr_at_valid <= is_receiving;
        end
        if (valid_prev) isr_after_valid <= is_receiving;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (break_det) n_brk <= n_brk + 1;
        if (frame_err && rx_valid) n_ferr_w_valid <= n_ferr_w_valid + 1;
        if (frame_err && break_det) n_ferr_w_brk <= n_ferr_w_brk + 1;
        if (any_prev && (rx_valid || frame_err || parity_err || break_det)) n_consec <= n_consec + 1;
        any_prev   <= rx_valid || frame_err || parity_err || break_det;
        valid_prev <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick_n(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    // Data bit 3 is inverted only around its mid sample (index 8): the index-7
    // and index-9 samples fall 4 clk either side and see the true value.
    task automatic send_frame_midflip(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx = d[i];
                tick_n(34);
                rx = ~d[i];
                tick_n(4);
                rx = d[i];
                tick_n(26);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
    endtask

`ifdef RXUART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
    endtask
`endif

    int b_valid, b_ferr, b_perr, b_brk, b_fwv, b_fwb;
    int gap;

    task automatic snap();
        b_valid = n_valid;
        b_ferr  = n_ferr;
        b_perr  = n_perr;
        b_brk   = n_brk;
        b_fwv   = n_ferr_w_valid;
        b_fwb   = n_ferr_w_brk;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        tick_n(5);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_break_det", 32'(break_det), 32'h0);
        check("rst_is_receiving", 32'(is_receiving), 32'h0);
        rst = 1'b0;
        tick_n(20);

        // 8N1 byte 0xA5
        snap();
        send_frame(8'hA5, 1'b1);
        tick_n(40);
        check("a5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("a5_data", 32'(d_last), 32'hA5);
        check("a5_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);
        check("a5_perr_cnt", 32'(n_perr - b_perr), 32'd0);
        check("a5_brk_cnt", 32'(n_brk - b_brk), 32'd0);
        check("a5_isr_at_valid", 32'(isr_at_valid), 32'h1);
        check("a5_isr_after_valid", 32'(isr_after_valid), 32'h0);
        check("a5_idle", 32'(is_receiving), 32'h0);

        // back-to-back 0x00 then 0xFF, no idle between frames
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick_n(40);
        check("b2b_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        check("b2b_data0", 32'(d_prev), 32'h00);
        check("b2b_data1", 32'(d_last), 32'hFF);
        check("b2b_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);
        check("b2b_brk_cnt", 32'(n_brk - b_brk), 32'd0);
        gap = t_valid_last - t_valid_prev;
        checks++;
        assert ((gap >= 638) && (gap <= 642)) else begin
            errors++;
            $error("FAIL b2b_gap observed=%0d expected=640+-2", gap);
        end

        // 0x3C with stop bit low: data still delivered, frame error alongside
        snap();
        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        tick_n(100);
        check("ferr_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
        check("ferr_with_valid", 32'(n_ferr_w_valid - b_fwv), 32'd1);
        check("ferr_data", 32'(d_last), 32'h3C);
        check("ferr_brk_cnt", 32'(n_brk - b_brk), 32'd0);
        check("ferr_idle", 32'(is_receiving), 32'h0);

`ifdef RXUART_PARITY_EN
        // even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
        snap();
        send_frame_par(8'h07, 1'b0);
        tick_n(40);
        check("par0_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("par0_perr_cnt", 32'(n_perr - b_perr), 32'd1);
        check("par0_data", 32'(d_last), 32'h07);
        snap();
        send_frame_par(8'h07, 1'b1);
        tick_n(40);
        check("par1_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("par1_perr_cnt", 32'(n_perr - b_perr), 32'd0);
`endif

        // 20-clk low pulse on an idle line
        snap();
        rx = 1'b0;
        tick_n(10);
        check("glitch_isr_high", 32'(is_receiving), 32'h1);
        tick_n(10);
        rx = 1'b1;
        tick_n(200);
        check("glitch_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("glitch_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);
        check("glitch_brk_cnt", 32'(n_brk - b_brk), 32'd0);
        check("glitch_idle", 32'(is_receiving), 32'h0);

        // one inverted sample in data bit 3 of 0x55 is outvoted
        snap();
        send_frame_midflip(8'h55);
        tick_n(40);
        check("vote_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("vote_data", 32'(d_last), 32'h55);
        check("vote_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);

        // line held low for two frame times
        snap();
        rx = 1'b0;
        tick_n(1280);
        check("brk_cnt", 32'(n_brk - b_brk), 32'd1);
        check("brk_ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
        check("brk_ferr_with_brk", 32'(n_ferr_w_brk - b_fwb), 32'd1);
        check("brk_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("brk_data_kept", 32'(rx_data), 32'h55);
        check("brk_wait_busy", 32'(is_receiving), 32'h1);
        rx = 1'b1;
        tick_n(100);
        check("brk_release_idle", 32'(is_receiving), 32'h0);
        send_frame(8'h81, 1'b1);
        tick_n(40);
        check("brk_after_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("brk_after_data", 32'(d_last), 32'h81);
        check("brk_after_brk_cnt", 32'(n_brk - b_brk), 32'd1);

        // 1-clk reset in mid-frame, then a clean frame
        snap();
        rx = 1'b0;
        tick_n(BIT_CLK);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        tick_n(30);
        rst = 1'b1;
        tick_n(1);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        check("mid_rst_brk", 32'(break_det), 32'h0);
        check("mid_rst_isr", 32'(is_receiving), 32'h0);
        rst = 1'b0;
        rx  = 1'b1;
        tick_n(100);
        check("mid_rst_idle", 32'(is_receiving), 32'h0);
        send_frame(8'hC3, 1'b1);
        tick_n(40);
        check("mid_rst_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("mid_rst_next_data", 32'(d_last), 32'hC3);
        check("mid_rst_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);

        check("no_consecutive_strobes", 32'(n_consec), 32'd0);
`ifndef RXUART_PARITY_EN
        check("parity_err_never", 32'(n_perr), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
